hazard_control_unit: RTL and testbench

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

---
 rtl/hcu_pkg.sv | 28 ++
 rtl/hcu_hazard_detect.sv | 31 +++
 rtl/hazard_control_unit.sv | 170 +++++++++++++++++
 tb/tb_hazard_control_unit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/hcu_pkg.sv
// ============================================================================
// Module : hcu_pkg
// Brief  : Shared types and widths for the hazard control unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package hcu_pkg;

    localparam int REG_IDX_W = 5;
    localparam int XLEN      = 32;
    localparam int CNT_W     = 3;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        FLUSH      = 2'd2,
        IMEM_WAIT  = 2'd3
    } hcu_state_e;

    // Remaining cycles to spend in a multi-cycle state after its entry cycle.
    function automatic logic [CNT_W-1:0] hold_init(input int total);
        return CNT_W'(total - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/hcu_hazard_detect.sv
// ============================================================================
// Module : hcu_hazard_detect
// Brief  : Combinational load-use check between the decode-stage load and the
//          source operands of the fetched instruction.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hcu_hazard_detect
    import hcu_pkg::*;
(
    input  logic                 id_is_load_i,
    input  logic [REG_IDX_W-1:0] id_rd_i,
    input  logic [REG_IDX_W-1:0] if_rs1_i,
    input  logic [REG_IDX_W-1:0] if_rs2_i,
    input  logic                 if_use_rs1_i,
    input  logic                 if_use_rs2_i,
    output logic                 load_use_o
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit    = if_use_rs1_i && (if_rs1_i == id_rd_i);
    assign rs2_hit    = if_use_rs2_i && (if_rs2_i == id_rd_i);
    // x0 is hardwired zero, so a load targeting it never creates a dependency.
    assign load_use_o = id_is_load_i && (id_rd_i != '0) && (rs1_hit || rs2_hit);

endmodule

`default_nettype wire

// File: rtl/hazard_control_unit.sv
// ============================================================================
// Module : hazard_control_unit
// Brief  : Pipeline stall / bubble / flush / redirect controller. Optional
//          performance counters are built when HCU_PERF_CNT_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_control_unit
    import hcu_pkg::*;
#(
    parameter int LOAD_LAT     = 1,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 id_is_load,
    input  logic [REG_IDX_W-1:0] id_rd,
    input  logic [REG_IDX_W-1:0] if_rs1,
    input  logic [REG_IDX_W-1:0] if_rs2,
    input  logic                 if_use_rs1,
    input  logic                 if_use_rs2,
    input  logic                 ex_branch_taken,
    input  logic [XLEN-1:0]      ex_branch_target,
    input  logic                 imem_ready,
    output logic                 stall,
    output logic                 bubble,
    output logic                 flush,
    output logic                 redirect_valid,
    output logic [XLEN-1:0]      redirect_pc,
    output logic [XLEN-1:0]      stall_cycles,
    output logic [XLEN-1:0]      flush_count
);

    localparam logic [CNT_W-1:0] c_load_init  = hold_init(LOAD_LAT);
    localparam logic [CNT_W-1:0] c_flush_init = hold_init(FLUSH_CYCLES);

    hcu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_use;

    hcu_hazard_detect u_detect (
        .id_is_load_i (id_is_load),
        .id_rd_i      (id_rd),
        .if_rs1_i     (if_rs1),
        .if_rs2_i     (if_rs2),
        .if_use_rs1_i (if_use_rs1),
        .if_use_rs2_i (if_use_rs2),
        .load_use_o   (load_use)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (ex_branch_taken) begin
            if (FLUSH_CYCLES > 1) begin
                state_d = FLUSH;
                cnt_d   = c_flush_init;
            end else begin
                state_d = RUN;
                cnt_d   = '0;
            end
        end else begin
            case (state_q)
                RUN, IMEM_WAIT: begin
                    if (load_use) begin
                        if (LOAD_LAT > 1) begin
                            state_d = LOAD_STALL;
                            cnt_d   = c_load_init;
                        end else begin
                            state_d = RUN;
                            cnt_d   = '0;
                        end
                    end else if (!imem_ready) begin
                        state_d = IMEM_WAIT;
                    end else begin
                        state_d = RUN;
                    end
                end
                // cnt holds the cycles left including this one; leave when it hits zero.
                LOAD_STALL, FLUSH: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        stall          = 1'b0;
        bubble         = 1'b0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if (reset) begin
            stall = 1'b0;
        end else if (ex_branch_taken) begin
            redirect_valid = 1'b1;
            redirect_pc    = ex_branch_target;
            flush          = 1'b1;
        end else begin
            case (state_q)
                RUN, IMEM_WAIT: begin
                    if (load_use) begin
                        stall  = 1'b1;
                        bubble = 1'b1;
                    end else if (!imem_ready) begin
                        stall  = 1'b1;
                    end
                end
                LOAD_STALL: begin
                    stall  = 1'b1;
                    bubble = 1'b1;
                end
                FLUSH: begin
                    flush  = 1'b1;
                end
                default: begin
                    stall  = 1'b0;
                end
            endcase
        end
    end

`ifdef HCU_PERF_CNT_EN
    logic [XLEN-1:0] stall_cycles_q;
    logic [XLEN-1:0] flush_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (stall && (stall_cycles_q != '1)) begin
                stall_cycles_q <= stall_cycles_q + XLEN'(1);
            end
            if (redirect_valid && (flush_count_q != '1)) begin
                flush_count_q  <= flush_count_q + XLEN'(1);
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_control_unit.sv
// ============================================================================
// Module : tb_hazard_control_unit
// Brief  : Directed bench for hazard_control_unit; a LOAD_LAT=1 and a
//          LOAD_LAT=3 instance share the stimulus.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hazard_control_unit;

    logic        clk;
    logic        reset;
    logic        id_is_load;
    logic [4:0]  id_rd, if_rs1, if_rs2;
    logic        if_use_rs1, if_use_rs2;
    logic        ex_branch_taken;
    logic [31:0] ex_branch_target;
    logic        imem_ready;

    logic        a_stall, a_bubble, a_flush, a_rv;
    logic [31:0] a_pc, a_sc, a_fc;
    logic        b_stall, b_bubble, b_flush, b_rv;
    logic [31:0] b_pc, b_sc, b_fc;

    // staged inputs, applied just after the next rising edge
    logic        n_rst, n_ld, n_u1, n_u2, n_br, n_rdy;
    logic [4:0]  n_rd, n_rs1, n_rs2;
    logic [31:0] n_tgt;

    typedef struct {
        string       tag;
        logic [35:0] a;
        logic [35:0] b;
    } exp_t;
    exp_t sb[$];

    int tests;
    int fails;
    logic        cnt_known;
    logic [31:0] exp_sc, exp_fc;

    localparam logic [3:0] E0  = 4'b0000;
    localparam logic [3:0] ES  = 4'b1000;
    localparam logic [3:0] ESB = 4'b1100;
    localparam logic [3:0] EF  = 4'b0010;
    localparam logic [3:0] EBR = 4'b0011;

    hazard_control_unit #(.LOAD_LAT(1), .FLUSH_CYCLES(2)) u_dut_a (
        .clk(clk), .reset(reset), .id_is_load(id_is_load), .id_rd(id_rd),
        .if_rs1(if_rs1), .if_rs2(if_rs2), .if_use_rs1(if_use_rs1), .if_use_rs2(if_use_rs2),
        .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
        .imem_ready(imem_ready), .stall(a_stall), .bubble(a_bubble), .flush(a_flush),
        .redirect_valid(a_rv), .redirect_pc(a_pc), .stall_cycles(a_sc), .flush_count(a_fc)
    );

    hazard_control_unit #(.LOAD_LAT(3), .FLUSH_CYCLES(2)) u_dut_b (
        .clk(clk), .reset(reset), .id_is_load(id_is_load), .id_rd(id_rd),
        .if_rs1(if_rs1), .if_rs2(if_rs2), .if_use_rs1(if_use_rs1), .if_use_rs2(if_use_rs2),
        .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
        .imem_ready(imem_ready), .stall(b_stall), .bubble(b_bubble), .flush(b_flush),
        .redirect_valid(b_rv), .redirect_pc(b_pc), .stall_cycles(b_sc), .flush_count(b_fc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        n_rst = 1'b0; n_ld = 1'b0; n_rd = 5'd0; n_rs1 = 5'd0; n_rs2 = 5'd0;
        n_u1 = 1'b0; n_u2 = 1'b0; n_br = 1'b0; n_tgt = 32'h0; n_rdy = 1'b1;
    endtask

    task automatic load_use(input logic [4:0] rd);
        n_ld = 1'b1; n_rd = rd; n_rs1 = rd; n_u1 = 1'b1;
    endtask

    task automatic step(input string tag, input logic [3:0] ea, input logic [3:0] eb);
        exp_t e;
        exp_t got;
        logic [35:0] obs_a, obs_b;
        @(posedge clk);
        #1;
        reset = n_rst; id_is_load = n_ld; id_rd = n_rd; if_rs1 = n_rs1; if_rs2 = n_rs2;
        if_use_rs1 = n_u1; if_use_rs2 = n_u2; ex_branch_taken = n_br;
        ex_branch_target = n_tgt; imem_ready = n_rdy;
        e.tag = tag;
        e.a   = {ea, ea[0] ? n_tgt : 32'h0};
        e.b   = {eb, eb[0] ? n_tgt : 32'h0};
        sb.push_back(e);
        #2;
        got   = sb.pop_front();
        obs_a = {a_stall, a_bubble, a_flush, a_rv, a_pc};
        obs_b = {b_stall, b_bubble, b_flush, b_rv, b_pc};
        tests++;
        assert (obs_a === got.a) else begin
            fails++;
            $error("FAIL %s/lat1 observed=%h expected=%h", got.tag, obs_a, got.a);
        end
        tests++;
        assert (obs_b === got.b) else begin
            fails++;
            $error("FAIL %s/lat3 observed=%h expected=%h", got.tag, obs_b, got.b);
        end
`ifdef HCU_PERF_CNT_EN
        if (cnt_known) begin
            tests++;
            assert ({a_sc, a_fc} === {exp_sc, exp_fc}) else begin
                fails++;
                $error("FAIL %s/cnt observed=%h/%h expected=%h/%h", got.tag, a_sc, a_fc, exp_sc, exp_fc);
            end
        end
        if (n_rst) begin
            exp_sc = 32'h0; exp_fc = 32'h0; cnt_known = 1'b1;
        end else begin
            exp_sc = exp_sc + {31'h0, ea[3]};
            exp_fc = exp_fc + {31'h0, ea[0]};
        end
`else
        tests++;
        assert ({a_sc, a_fc, b_sc, b_fc} === 128'h0) else begin
            fails++;
            $error("FAIL %s/cnt observed=%h/%h expected=0/0", got.tag, a_sc, a_fc);
        end
`endif
    endtask

    initial begin
        tests = 0; fails = 0; cnt_known = 1'b0; exp_sc = 32'h0; exp_fc = 32'h0;
        reset = 1'b1; id_is_load = 1'b0; id_rd = 5'd0; if_rs1 = 5'd0; if_rs2 = 5'd0;
        if_use_rs1 = 1'b0; if_use_rs2 = 1'b0; ex_branch_taken = 1'b0;
        ex_branch_target = 32'h0; imem_ready = 1'b1;

        // reset masks every event
        idle(); n_rst = 1'b1; n_br = 1'b1; n_tgt = 32'hDEAD_BEEF; load_use(5'd3);
        step("rst_masks", E0, E0);
        idle(); n_rst = 1'b1;                      step("rst_hold", E0, E0);
        idle();                                    step("run_idle", E0, E0);

        // load-use via rs1
        idle(); load_use(5'd5);                    step("lu_rs1", ESB, ESB);
        idle();                                    step("lu_rs1_c1", E0, ESB);
        idle();                                    step("lu_rs1_c2", E0, ESB);
        idle();                                    step("lu_rs1_end", E0, E0);

        // x0 destination, and operand match without use flag
        idle(); load_use(5'd0);                    step("lu_rd0", E0, E0);
        idle(); load_use(5'd9); n_u1 = 1'b0;       step("lu_nouse", E0, E0);

        // load-use via rs2
        idle(); n_ld = 1'b1; n_rd = 5'd7; n_rs1 = 5'd7; n_rs2 = 5'd7; n_u2 = 1'b1;
        step("lu_rs2", ESB, ESB);
        idle();                                    step("lu_rs2_c1", E0, ESB);
        idle();                                    step("lu_rs2_c2", E0, ESB);
        idle();                                    step("lu_rs2_end", E0, E0);

        // taken branch: one redirect cycle, two flush cycles
        idle(); n_br = 1'b1; n_tgt = 32'h100;      step("br_redirect", EBR, EBR);
        idle();                                    step("br_flush2", EF, EF);
        idle();                                    step("br_done", E0, E0);

        // instruction memory not ready for three cycles
        idle(); n_rdy = 1'b0;                      step("imem_w1", ES, ES);
        idle(); n_rdy = 1'b0;                      step("imem_w2", ES, ES);
        idle(); n_rdy = 1'b0;                      step("imem_w3", ES, ES);
        idle();                                    step("imem_ok", E0, E0);

        // branch in the 2nd LOAD_STALL cycle of the LOAD_LAT=3 instance
        idle(); load_use(5'd12);                   step("lsbr_lu", ESB, ESB);
        idle();                                    step("lsbr_ls1", E0, ESB);
        idle(); n_br = 1'b1; n_tgt = 32'h200;      step("lsbr_branch", EBR, EBR);
        idle();                                    step("lsbr_flush", EF, EF);
        idle();                                    step("lsbr_done", E0, E0);

        // branch aborts an instruction-memory wait
        idle(); n_rdy = 1'b0;                      step("iwbr_wait", ES, ES);
        idle(); n_rdy = 1'b0; n_br = 1'b1; n_tgt = 32'h0000_4440;
        step("iwbr_branch", EBR, EBR);
        idle();                                    step("iwbr_flush", EF, EF);
        idle();                                    step("iwbr_done", E0, E0);

        // priority: branch over load-use, load-use over imem wait
        idle(); load_use(5'd20); n_br = 1'b1; n_tgt = 32'hFFFF_FFFC;
        step("pri_br_lu", EBR, EBR);
        idle();                                    step("pri_br_flush", EF, EF);
        idle();                                    step("pri_br_done", E0, E0);
        idle(); load_use(5'd31); n_rdy = 1'b0;     step("pri_lu_imem", ESB, ESB);
        idle();                                    step("pri_lu_c1", E0, ESB);
        idle();                                    step("pri_lu_c2", E0, ESB);
        idle();                                    step("pri_lu_done", E0, E0);

        // reset in the middle of FLUSH
        idle(); n_br = 1'b1; n_tgt = 32'h300;      step("rstfl_branch", EBR, EBR);
        idle(); n_rst = 1'b1;                      step("rstfl_reset", E0, E0);
        idle();                                    step("rstfl_after", E0, E0);
        idle();                                    step("rstfl_idle", E0, E0);

        tests++;
        assert (sb.size() == 0) else begin
            fails++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
